// File: rtl/fxp_pkg.sv
// Shared definitions for the signed fixed-point ALU: op codes, FSM states, saturation.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
//
// Contents: OP_ADD/OP_SUB/OP_MUL/OP_DIV op encodings, state_t (IDLE, DIV, FIN),
// sat_t result record and saturate() which clamps a wide signed value to w bits.
package fxp_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Wide enough for a 2*32-bit product or a 63-bit quotient plus sign.
  localparam int SAT_IN_W  = 65;
  localparam int SAT_OUT_W = 32;

  typedef struct packed {
    logic [SAT_OUT_W-1:0] val;
    logic                 ovf;
  } sat_t;

  // Clamp v into [-2^(w-1), 2^(w-1)-1]; val holds the result in its low w bits.
  function automatic sat_t saturate(input logic signed [SAT_IN_W-1:0] v, input int w);
    logic signed [SAT_IN_W-1:0] one;
    logic signed [SAT_IN_W-1:0] maxv;
    logic signed [SAT_IN_W-1:0] minv;
    sat_t                       r;
    one   = {{(SAT_IN_W-1){1'b0}}, 1'b1};
    maxv  = (one << (w - 1)) - one;
    minv  = ~maxv;
    r.val = v[SAT_OUT_W-1:0];
    r.ovf = 1'b0;
    if (v > maxv) begin
      r.val = maxv[SAT_OUT_W-1:0];
      r.ovf = 1'b1;
    end else if (v < minv) begin
      r.val = minv[SAT_OUT_W-1:0];
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fxp_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Latency: DW cycles after start; done is high during the final iteration cycle.
// Backpressure: none; the quotient register holds until the next start.
//
// Ports: clk, rst (async active-low), start (load operands), dividend [DW-1:0],
// divisor [VW-1:0] (non-zero), done (last iteration this cycle), quotient [DW-1:0].
module fxp_seq_divider #(
  parameter int DW = 24,
  parameter int VW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quotient
);

  localparam int CW = $clog2(DW + 1);

  // q starts as the dividend and is shifted left; quotient bits fill in from the bottom.
  logic [DW-1:0] q;
  logic [VW-1:0] rem;
  logic [VW-1:0] dvs;
  logic [CW-1:0] cnt;
  logic [VW:0]   rem_sh;
  logic [VW:0]   diff;
  logic          ge;

  assign rem_sh = {rem, q[DW-1]};
  assign ge     = rem_sh >= {1'b0, dvs};
  assign diff   = rem_sh - {1'b0, dvs};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (start) begin
      q   <= dividend;
      rem <= '0;
      dvs <= divisor;
      cnt <= CW'(DW);
    end else if (cnt != '0) begin
      q   <= {q[DW-2:0], ge};
      // When ge holds, diff < dvs so its top bit is always zero.
      rem <= ge ? diff[VW-1:0] : rem_sh[VW-1:0];
      cnt <= cnt - CW'(1);
    end
  end

  assign done     = (cnt == CW'(1));
  assign quotient = q;

  logic unused_diff_msb;
  assign unused_diff_msb = diff[VW];

endmodule

// File: rtl/fixed_point_alu.sv
// Signed Q(WIDTH-FRAC).FRAC add/sub/mul/div with saturation and overflow/div-by-zero flags.
// Latency: ADD/SUB/MUL/DIV-by-zero register on the acceptance edge; DIV loads WIDTH+FRAC+1 edges later.
// Backpressure: result held while out_valid && !out_ready; in_ready low while dividing or held.
//
// Ports: clk, rst (async active-low), in_valid/in_ready, op (00 add, 01 sub, 10 mul, 11 div),
// a, b [WIDTH-1:0] signed operands, out_valid/out_ready, result [WIDTH-1:0],
// ovf (saturated), div_zero (DIV with b==0), busy (division in progress).
module fixed_point_alu
  import fxp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             div_zero,
  output logic             busy
);

  localparam int DW     = WIDTH + FRAC;
  localparam int XW_PAD = SAT_IN_W - (WIDTH + 1);
  localparam int PW_PAD = SAT_IN_W - 2 * WIDTH;
  localparam int QW_PAD = SAT_IN_W - DW;

  state_t state;
  logic   out_free;
  logic   accept;
  logic   b_zero;
  logic   div_start;

  assign out_free  = !out_valid || out_ready;
  assign in_ready  = (state == IDLE) && out_free;
  assign accept    = in_valid && in_ready;
  assign b_zero    = (b == '0);
  assign div_start = accept && (op == OP_DIV) && !b_zero;
  assign busy      = (state != IDLE);

  // ---------------- single-cycle datapath ----------------
  logic signed [WIDTH:0]        a_x, b_x, sum_x, dif_x, abs_a, abs_b;
  logic signed [2*WIDTH-1:0]    prod, prod_sh;
  logic signed [SAT_IN_W-1:0]   ar_wide;
  sat_t                         ar_sat;
  logic        [WIDTH-1:0]      dz_val;

  assign a_x     = {a[WIDTH-1], a};
  assign b_x     = {b[WIDTH-1], b};
  assign sum_x   = a_x + b_x;
  assign dif_x   = a_x - b_x;
  assign prod    = $signed(a) * $signed(b);
  // Arithmetic shift truncates toward -inf.
  assign prod_sh = prod >>> FRAC;

  always_comb begin
    ar_wide = '0;
    case (op)
      OP_ADD:  ar_wide = {{XW_PAD{sum_x[WIDTH]}}, sum_x};
      OP_SUB:  ar_wide = {{XW_PAD{dif_x[WIDTH]}}, dif_x};
      OP_MUL:  ar_wide = {{PW_PAD{prod_sh[2*WIDTH-1]}}, prod_sh};
      default: ar_wide = '0;
    endcase
  end

  assign ar_sat = saturate(ar_wide, WIDTH);

  // Division by zero saturates toward the sign of the dividend.
  assign dz_val = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

  // ---------------- iterative divide ----------------
  // Magnitudes at WIDTH+1 bits so the most negative operand does not wrap.
  logic [DW-1:0]              dvd_in;
  logic [DW-1:0]              dv_q;
  logic                       dv_done;
  logic                       q_neg;
  logic signed [SAT_IN_W-1:0] q_mag, q_wide;
  sat_t                       dv_sat;

  assign abs_a  = a[WIDTH-1] ? -a_x : a_x;
  assign abs_b  = b[WIDTH-1] ? -b_x : b_x;
  assign dvd_in = DW'(abs_a[WIDTH-1:0]) << FRAC;

  fxp_seq_divider #(
    .DW (DW),
    .VW (WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (dvd_in),
    .divisor  (abs_b[WIDTH-1:0]),
    .done     (dv_done),
    .quotient (dv_q)
  );

  // Sign is applied to the magnitude quotient, giving truncation toward zero.
  assign q_mag  = {{QW_PAD{1'b0}}, dv_q};
  assign q_wide = q_neg ? -q_mag : q_mag;
  assign dv_sat = saturate(q_wide, WIDTH);

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      q_neg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (div_start) begin
          state <= DIV;
          q_neg <= a[WIDTH-1] ^ b[WIDTH-1];
        end
        DIV:  if (dv_done) state <= FIN;
        // FIN stalls here until the output register is free.
        FIN:  if (out_free) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      div_zero  <= 1'b0;
    end else if (accept && (op != OP_DIV)) begin
      out_valid <= 1'b1;
      result    <= ar_sat.val[WIDTH-1:0];
      ovf       <= ar_sat.ovf;
      div_zero  <= 1'b0;
    end else if (accept && b_zero) begin
      out_valid <= 1'b1;
      result    <= dz_val;
      ovf       <= 1'b0;
      div_zero  <= 1'b1;
    end else if ((state == FIN) && out_free) begin
      out_valid <= 1'b1;
      result    <= dv_sat.val[WIDTH-1:0];
      ovf       <= dv_sat.ovf;
      div_zero  <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Bits beyond WIDTH in the saturate record and the magnitude sign bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{ar_sat.val, dv_sat.val, abs_a[WIDTH], abs_b[WIDTH]};

endmodule

// File: tb/tb_fixed_point_alu.sv
module tb_fixed_point_alu;

  localparam int W = 16;
  localparam int F = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          ovf;
  logic          div_zero;
  logic          busy;

  always #5 clk = ~clk;

  fixed_point_alu #(.WIDTH(W), .FRAC(F)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  // rise = edges from the acceptance edge to the edge that raises out_valid.
  typedef struct {
    logic [W-1:0] r;
    logic         ovf;
    logic         dz;
    int           rise;
    longint       t;
  } exp_t;

  exp_t sb[$];
  bit   front_seen = 1'b0;

  // Reference arithmetic on plain integers.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic ov, output logic dz,
                                output int rise);
    longint sa, sy, v, maxv, minv;
    sa   = longint'($signed(x));
    sy   = longint'($signed(y));
    maxv = (64'sd1 <<< (W - 1)) - 1;
    minv = -(64'sd1 <<< (W - 1));
    dz   = 1'b0;
    rise = 0;
    case (o)
      2'd0: v = sa + sy;
      2'd1: v = sa - sy;
      2'd2: v = (sa * sy) >>> F;
      default: begin
        if (sy == 0) begin
          dz = 1'b1;
          v  = (sa >= 0) ? maxv : minv;
        end else begin
          v    = (sa * (64'sd1 <<< F)) / sy;
          rise = W + F + 1;
        end
      end
    endcase
    ov = !dz && ((v > maxv) || (v < minv));
    if (v > maxv) v = maxv;
    if (v < minv) v = minv;
    r = W'(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one transaction, wait (bounded) for acceptance, record the expectation.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int waited);
    exp_t e;
    logic rdy;
    model(o, x, y, e.r, e.ovf, e.dz, e.rise);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    waited   = 0;
    rdy      = 1'b0;
    while (!rdy && waited <= 200) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (!rdy) waited++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op %0d a %h b %h never accepted", o, x, y);
    end else begin
      e.t = longint'($time);
      sb.push_back(e);
    end
    #1;
    in_valid = 1'b0;
  endtask

  // Pin the model with a hand-computed literal, then run the vector through the DUT.
  task automatic vec(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] er, input logic eo, input logic ed);
    logic [W-1:0] r;
    logic         ov, dz;
    int           rise, waited;
    model(o, x, y, r, ov, dz, rise);
    check("model_literal", {14'd0, r, ov, dz}, {14'd0, er, eo, ed});
    do_op(o, x, y, waited);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Compare process: every cycle out_valid is high, the output must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t   e;
    longint seen;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: result %h ovf %b div_zero %b with nothing outstanding",
                 result, ovf, div_zero);
      end else begin
        e = sb[0];
        check("output", {13'd0, result, ovf, div_zero, 1'b0}, {13'd0, e.r, e.ovf, e.dz, 1'b0});
        if (!front_seen) begin
          seen = (longint'($time) - 5 - e.t) / 10;
          check("latency", 32'(seen), 32'(e.rise));
          front_seen = 1'b1;
        end
        if (out_ready) begin
          void'(sb.pop_front());
          front_seen = 1'b0;
        end
      end
    end
  end

  initial begin : stim
    int waited;
    // Reset state.
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'(result),    32'd0);
    check("rst_flags",     {30'd0, ovf, div_zero}, 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    #9 rst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Single-cycle ops, issued back to back.
    vec(2'd0, 16'h0180, 16'h0240, 16'h03C0, 1'b0, 1'b0);
    vec(2'd1, 16'h0180, 16'h0240, 16'hFF40, 1'b0, 1'b0);
    vec(2'd0, 16'h7F00, 16'h0200, 16'h7FFF, 1'b1, 1'b0);
    vec(2'd1, 16'h8000, 16'h0100, 16'h8000, 1'b1, 1'b0);
    vec(2'd0, 16'h8000, 16'h8000, 16'h8000, 1'b1, 1'b0);
    vec(2'd2, 16'hFE80, 16'h0200, 16'hFD00, 1'b0, 1'b0);
    vec(2'd2, 16'h1000, 16'h1000, 16'h7FFF, 1'b1, 1'b0);
    vec(2'd2, 16'hFFFF, 16'h0080, 16'hFFFF, 1'b0, 1'b0);
    vec(2'd3, 16'hFD00, 16'h0000, 16'h8000, 1'b0, 1'b1);
    vec(2'd3, 16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1);
    drain();

    // Iterative divide: busy and in_ready across the whole division.
    vec(2'd3, 16'h0700, 16'h0200, 16'h0380, 1'b0, 1'b0);
    for (int i = 0; i < W + F + 1; i++) begin
      @(negedge clk);
      check("div_busy",     32'(busy),     32'd1);
      check("div_in_ready", 32'(in_ready), 32'd0);
    end
    vec(2'd3, 16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0);
    vec(2'd3, 16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0);
    vec(2'd3, 16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b0);
    drain();

    // Backpressure: held result, no acceptance, then accept on the releasing edge.
    out_ready = 1'b0;
    vec(2'd0, 16'h0100, 16'h0100, 16'h0200, 1'b0, 1'b0);
    in_valid = 1'b1;
    op       = 2'd1;
    a        = 16'h0300;
    b        = 16'h0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_result",   32'(result),   32'h0200);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    do_op(2'd1, 16'h0300, 16'h0100, waited);
    check("bp_accept_same_edge", 32'(waited), 32'd0);
    drain();

    // Asynchronous reset in the middle of a division.
    do_op(2'd3, 16'h0700, 16'h0200, waited);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_result",    32'(result),    32'd0);
    check("arst_flags",     {30'd0, ovf, div_zero}, 32'd0);
    sb.delete();
    front_seen = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy",     32'(busy),     32'd0);
    repeat (30) @(posedge clk);
    #1;
    vec(2'd0, 16'h0180, 16'h0240, 16'h03C0, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_point_alu.md
Name: fixed_point_alu

Overview:
- Parametrised signed fixed-point arithmetic unit in two's-complement Q(WIDTH-FRAC).FRAC format.
- Performs add, subtract, multiply or divide on one operand pair per transaction, with saturation and status flags.
- Sits between the operand source and the result consumer, with valid/ready handshakes on both sides.
- Replaces the fixed 8-bit integer calculator: adds a selectable operation, fractional scaling, saturation, an iterative divider and backpressure.

Parameters:
- WIDTH, 16, total operand/result width in bits (4..32).
- FRAC, 8, fractional bits (0..WIDTH-1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair and op are valid.
- in_ready  out  1  block can accept a transaction.
- op  in  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- a  in  WIDTH  signed operand A.
- b  in  WIDTH  signed operand B.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  signed saturated result.
- ovf  out  1  result was saturated.
- div_zero  out  1  DIV with b==0.
- busy  out  1  divider iteration in progress.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; out_valid=0, result=0, ovf=0, div_zero=0, busy=0. A reset mid-division aborts the division with no output.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A transaction is accepted on a rising edge where in_valid && in_ready. Inputs are sampled only at acceptance.
- Output hold: while out_valid && !out_ready, result, ovf and div_zero stay stable. out_valid clears on the edge where out_ready is high unless a new result loads on the same edge. Back-to-back single-cycle operations sustain one result per cycle.
- ADD/SUB: computed at WIDTH+1 bits and saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. ovf=1 if clipped. Latency 1: result registered on the acceptance edge.
- MUL: full 2*WIDTH-bit signed product, arithmetically shifted right by FRAC (truncation toward -inf), then saturated to WIDTH. ovf as above. Latency 1.
- DIV, b==0: no iteration. result = max positive if a>=0, otherwise most negative. div_zero=1, ovf=0. Latency 1.
- DIV, b!=0: FSM IDLE -> DIV -> FIN -> IDLE.
  - Acceptance edge: latch |a|<<FRAC as the WIDTH+FRAC-bit dividend, |b| as the divisor, and quotient sign = sign(a)^sign(b). busy=1.
  - DIV state: restoring division, one quotient bit per cycle, for WIDTH+FRAC cycles (counter, then to FIN).
  - FIN state: apply sign (truncation toward zero), saturate to WIDTH (ovf), load the output register, busy=0, return to IDLE.
  - out_valid rises WIDTH+FRAC+1 cycles after acceptance (25 at defaults).
  - FIN waits in place if the output register is still held (out_valid && !out_ready).
- Absolute values of the most negative operand are computed at WIDTH+1 bits, so no wrap occurs.
- ovf and div_zero are mutually exclusive. Both are 0 for in-range results.

Decomposition:
- Package fxp_pkg: op encoding constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV), FSM state typedef (IDLE, DIV, FIN), and a saturate function (wide signed value to WIDTH with overflow flag).
- Sub-module fxp_seq_divider: unsigned restoring divider with start/done and WIDTH+FRAC iterations. The top level keeps the sign, saturation, the handshake and the output register.

Test Plan (Q8.8 defaults):
- ADD a=0x0180 (1.5), b=0x0240 (2.25), out_ready=1 -> result 0x03C0, ovf=0, out_valid one cycle after acceptance. Repeat for SUB of the same operands -> 0xFF40.
- ADD a=0x7F00, b=0x0200 -> result 0x7FFF, ovf=1. SUB a=0x8000, b=0x0100 -> 0x8000, ovf=1.
- MUL a=0xFE80 (-1.5), b=0x0200 (2.0) -> 0xFD00. MUL a=0x1000, b=0x1000 (16*16) -> 0x7FFF, ovf=1.
- DIV a=0x0700 (7.0), b=0x0200 (2.0) -> 0x0380 after exactly 25 cycles, busy high throughout, in_ready=0. DIV a=0x8000, b=0xFF00 (-128/-1) -> 0x7FFF, ovf=1. DIV a=0xFD00, b=0x0000 -> 0x8000, div_zero=1, latency 1.
- Backpressure: hold out_ready=0 after a result with in_valid=1 -> result stable, in_ready=0, no new acceptance. Raise out_ready -> next operation accepted on the same edge.
- Drive rst=0 asynchronously 10 cycles into a DIV -> all outputs 0 immediately. After release, state IDLE with in_ready=1, and no stale result appears.
